// File: rtl/lcd_capture.sv
// lcd_capture: receives the gameboy LCD pixel stream, packs 2-bit pixels
// four per byte and writes each frame linearly into a framebuffer.
// Reports per-frame completion and sticky line/frame protocol errors.
module lcd_capture #(
    parameter int WIDTH       = 160,
    parameter int HEIGHT      = 144,
    parameter int ADDR_W      = 13,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              capture_en,
    input  logic              err_clear,
    input  logic [1:0]        pixel_data,
    input  logic              pixel_clock,
    input  logic              pixel_latch,
    input  logic              hsync,
    input  logic              vsync,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [7:0]        fb_wr_data,
    output logic              fb_wr_en,
    output logic              frame_done,
    output logic              busy,
    output logic [7:0]        row,
    output logic              err_short,
    output logic              err_long,
    output logic              err_frame
);

    localparam int COL_W = $clog2(WIDTH + 1);
    localparam int LAST  = SYNC_STAGES - 1;

    localparam logic [COL_W-1:0]  WIDTH_C  = COL_W'(WIDTH);
    localparam logic [7:0]        HEIGHT_C = 8'(HEIGHT);
    localparam logic [ADDR_W-1:0] BPL_C    = ADDR_W'(WIDTH / 4);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_LINE  = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    // Bit layout of the sampled video bundle: {data[1:0], pclk, latch, hsync, vsync}
    logic [5:0] video;
    logic [5:0] sync_q [SYNC_STAGES];
    logic [3:0] edge_q;

    logic       pix_evt;
    logic       latch_evt;
    logic       hs_evt;
    logic       vs_evt;
    logic [1:0] pix_val;

    logic [1:0]        state;
    logic [COL_W-1:0]  col;
    logic [7:0]        pack;
    logic [2:0]        cnt;
    logic [ADDR_W-1:0] line_base;
    logic [ADDR_W-1:0] bidx;

    logic set_short;
    logic set_long;
    logic set_frame;

    // Left-align a partially filled pack register, zero-padding the low pixels.
    function automatic logic [7:0] left_align(input logic [7:0] p, input logic [2:0] n);
        case (n)
            3'd1:    return {p[1:0], 6'b0};
            3'd2:    return {p[3:0], 4'b0};
            3'd3:    return {p[5:0], 2'b0};
            default: return p;
        endcase
    endfunction

    assign video = {pixel_data, pixel_clock, pixel_latch, hsync, vsync};

    // Synchronizer chain plus one edge-detect flop; data rides the same chain as its strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            edge_q <= '0;
        end else begin
            sync_q[0] <= video;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            edge_q <= sync_q[LAST][3:0];
        end
    end

    assign pix_evt   = sync_q[LAST][3] & ~edge_q[3];
    assign latch_evt = sync_q[LAST][2] & ~edge_q[2];
    assign hs_evt    = sync_q[LAST][1] & ~edge_q[1];
    assign vs_evt    = sync_q[LAST][0] & ~edge_q[0];
    assign pix_val   = sync_q[LAST][5:4];

    assign busy = (state != S_IDLE);

    // Error conditions detected this cycle.
    always_comb begin
        set_frame = vs_evt & ((state == S_WAIT) | (state == S_LINE));
        set_long  = (state == S_LINE) & ~vs_evt & pix_evt & (col >= WIDTH_C);
        set_short = (state == S_FLUSH) & (col < WIDTH_C);
    end

    // Sticky error flags; a new error in the same cycle as err_clear wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_short <= 1'b0;
            err_long  <= 1'b0;
            err_frame <= 1'b0;
        end else begin
            err_short <= (err_short & ~err_clear) | set_short;
            err_long  <= (err_long  & ~err_clear) | set_long;
            err_frame <= (err_frame & ~err_clear) | set_frame;
        end
    end

    // Capture FSM: line tracking, pixel packing and framebuffer writes.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            col        <= '0;
            pack       <= '0;
            cnt        <= '0;
            line_base  <= '0;
            bidx       <= '0;
            row        <= '0;
            fb_addr    <= '0;
            fb_wr_data <= '0;
            fb_wr_en   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            fb_wr_en   <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (vs_evt && capture_en) begin
                        state     <= S_WAIT;
                        row       <= '0;
                        line_base <= '0;
                    end
                end
                S_WAIT: begin
                    if (vs_evt) begin
                        row       <= '0;
                        line_base <= '0;
                    end else if (hs_evt) begin
                        state <= S_LINE;
                        col   <= '0;
                        cnt   <= '0;
                        pack  <= '0;
                        bidx  <= '0;
                    end
                end
                S_LINE: begin
                    if (vs_evt) begin
                        // Frame restart: pending pixels are discarded.
                        state     <= S_WAIT;
                        row       <= '0;
                        line_base <= '0;
                        col       <= '0;
                        cnt       <= '0;
                    end else begin
                        if (pix_evt && (col < WIDTH_C)) begin
                            pack <= {pack[5:0], pix_val};
                            col  <= col + 1'b1;
                            // A byte completed together with the latch is left for FLUSH.
                            if ((cnt == 3'd3) && !latch_evt) begin
                                fb_wr_en   <= 1'b1;
                                fb_addr    <= line_base + bidx;
                                fb_wr_data <= {pack[5:0], pix_val};
                                bidx       <= bidx + 1'b1;
                                cnt        <= '0;
                            end else begin
                                cnt <= cnt + 3'd1;
                            end
                        end
                        if (latch_evt) state <= S_FLUSH;
                    end
                end
                default: begin
                    if (cnt != 3'd0) begin
                        fb_wr_en   <= 1'b1;
                        fb_addr    <= line_base + bidx;
                        fb_wr_data <= left_align(pack, cnt);
                        bidx       <= bidx + 1'b1;
                    end
                    cnt       <= '0;
                    row       <= row + 8'd1;
                    line_base <= line_base + BPL_C;
                    if ((row + 8'd1) == HEIGHT_C) begin
                        frame_done <= 1'b1;
                        state      <= S_IDLE;
                    end else begin
                        state <= S_WAIT;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_capture.sv
// tb_lcd_capture: randomized stimulus with a frame-level reference model;
// expected framebuffer writes are queued at stimulus time and a separate
// monitor compares every write the DUT issues.
module tb_lcd_capture;

    localparam int W   = 160;
    localparam int H   = 144;
    localparam int AW  = 13;
    localparam int BPL = W / 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          capture_en = 1'b0;
    logic          err_clear = 1'b0;
    logic [1:0]    pixel_data = 2'd0;
    logic          pixel_clock = 1'b0;
    logic          pixel_latch = 1'b0;
    logic          hsync = 1'b0;
    logic          vsync = 1'b0;
    logic [AW-1:0] fb_addr;
    logic [7:0]    fb_wr_data;
    logic          fb_wr_en;
    logic          frame_done;
    logic          busy;
    logic [7:0]    row;
    logic          err_short;
    logic          err_long;
    logic          err_frame;

    lcd_capture #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .SYNC_STAGES(2)) dut (
        .clock(clock), .reset(reset), .capture_en(capture_en), .err_clear(err_clear),
        .pixel_data(pixel_data), .pixel_clock(pixel_clock), .pixel_latch(pixel_latch),
        .hsync(hsync), .vsync(vsync), .fb_addr(fb_addr), .fb_wr_data(fb_wr_data),
        .fb_wr_en(fb_wr_en), .frame_done(frame_done), .busy(busy), .row(row),
        .err_short(err_short), .err_long(err_long), .err_frame(err_frame)
    );

    always #5 clock = ~clock;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  cur_px[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  done_seen = 0;

    // Reference model state
    bit m_idle = 1'b1;
    int m_row  = 0;
    bit m_es = 1'b0, m_el = 1'b0, m_ef = 1'b0;
    int m_done = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every DUT write must match the oldest expected write.
    always @(negedge clock) begin
        wr_t e;
        if (frame_done) done_seen++;
        if (fb_wr_en) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data %h, required no write", fb_addr, fb_wr_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", int'(fb_addr), e.addr);
                check("wr_data", int'(fb_wr_data), e.data);
            end
        end
    end

    initial begin
        repeat (150000) @(posedge clock);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Model a line from cur_px: packed bytes, errors, row advance.
    task automatic model_line(input bit aborted);
        int m, nb, b, k, idx, byt;
        wr_t e;
        if (m_idle) return;
        m  = (cur_px.size() > W) ? W : cur_px.size();
        nb = aborted ? (m / 4) : ((m + 3) / 4);
        for (b = 0; b < nb; b++) begin
            byt = 0;
            for (k = 0; k < 4; k++) begin
                idx = b * 4 + k;
                if (idx < m) byt = byt | (cur_px[idx] << (6 - 2 * k));
            end
            e.addr = m_row * BPL + b;
            e.data = byt;
            exp_q.push_back(e);
        end
        if (aborted) return;
        if (cur_px.size() < W) m_es = 1'b1;
        if (cur_px.size() > W) m_el = 1'b1;
        m_row++;
        if (m_row == H) begin
            m_done++;
            m_idle = 1'b1;
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "_row"}, int'(row), m_row);
        check({tag, "_busy"}, int'(busy), int'(!m_idle));
        check({tag, "_err_short"}, int'(err_short), int'(m_es));
        check({tag, "_err_long"}, int'(err_long), int'(m_el));
        check({tag, "_err_frame"}, int'(err_frame), int'(m_ef));
        check({tag, "_pending_writes"}, exp_q.size(), 0);
        check({tag, "_frame_done_count"}, done_seen, m_done);
    endtask

    task automatic do_vsync();
        if (m_idle) begin
            if (capture_en) begin
                m_idle = 1'b0;
                m_row  = 0;
            end
        end else begin
            m_ef  = 1'b1;
            m_row = 0;
        end
        @(negedge clock) vsync = 1'b1;
        @(negedge clock) vsync = 1'b0;
        tick(6);
    endtask

    task automatic do_clear();
        m_es = 1'b0; m_el = 1'b0; m_ef = 1'b0;
        @(negedge clock) err_clear = 1'b1;
        @(negedge clock) err_clear = 1'b0;
        tick(1);
    endtask

    // mode: 0 = col mod 4, 1 = random, 2 = use cur_px as preloaded
    task automatic send_line(input int n, input int mode, input bit coincide);
        if (mode != 2) begin
            cur_px.delete();
            for (int i = 0; i < n; i++)
                cur_px.push_back(mode == 0 ? (i % 4) : int'($urandom_range(0, 3)));
        end
        model_line(1'b0);
        @(negedge clock) hsync = 1'b1;
        @(negedge clock) hsync = 1'b0;
        tick(2);
        for (int i = 0; i < cur_px.size(); i++) begin
            @(negedge clock);
            pixel_data  = 2'(cur_px[i]);
            pixel_clock = 1'b1;
            if (coincide && (i == cur_px.size() - 1)) pixel_latch = 1'b1;
            @(negedge clock);
            pixel_clock = 1'b0;
            pixel_latch = 1'b0;
        end
        if (!coincide) begin
            @(negedge clock) pixel_latch = 1'b1;
            @(negedge clock) pixel_latch = 1'b0;
        end
        tick(6);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fb_addr"}, int'(fb_addr), 0);
        check({tag, "_fb_wr_data"}, int'(fb_wr_data), 0);
        check({tag, "_fb_wr_en"}, int'(fb_wr_en), 0);
        check({tag, "_frame_done"}, int'(frame_done), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_row"}, int'(row), 0);
        check({tag, "_errors"}, int'({err_short, err_long, err_frame}), 0);
    endtask

    initial begin
        // Reset state
        tick(3);
        check_reset_outputs("reset");
        @(negedge clock) reset = 1'b0;
        tick(2);

        // Capture with an early vsync after 10 lines, then one full frame
        capture_en = 1'b1;
        do_vsync();
        for (int l = 0; l < 10; l++) send_line(W, 1, 1'b0);
        check_status("ten_lines");
        do_vsync();
        check_status("early_vsync");
        do_clear();
        check_status("err_clear");
        for (int l = 0; l < H; l++) begin
            send_line(W, 0, 1'b0);
            check_status("full_frame");
        end
        check("full_frame_done_once", done_seen, 1);

        // Short line: 6 pixels on line 0
        do_vsync();
        cur_px = '{3, 2, 1, 0, 3, 3};
        send_line(6, 2, 1'b0);
        check_status("short_line");
        check("short_err_short", int'(err_short), 1);
        do_clear();

        // Long line on row 0 (vsync restart mid-frame)
        do_vsync();
        send_line(W + 4, 1, 1'b0);
        check_status("long_line");
        check("long_err_long", int'(err_long), 1);
        do_clear();

        // Last pixel and latch on the same clock
        do_vsync();
        send_line(W, 1, 1'b1);
        check_status("coincident");
        do_clear();

        // Random-length lines
        for (int l = 0; l < 2; l++) begin
            send_line(int'($urandom_range(1, W + 10)), 1, 1'b0);
            check_status("random_len");
        end
        do_clear();

        // Reset after 50 pixels of line 3
        cur_px.delete();
        for (int i = 0; i < 50; i++) cur_px.push_back(int'($urandom_range(0, 3)));
        model_line(1'b1);
        @(negedge clock) hsync = 1'b1;
        @(negedge clock) hsync = 1'b0;
        tick(2);
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            pixel_data  = 2'(cur_px[i]);
            pixel_clock = 1'b1;
            @(negedge clock);
            pixel_clock = 1'b0;
        end
        tick(6);
        check("pre_reset_pending_writes", exp_q.size(), 0);
        @(negedge clock) reset = 1'b1;
        @(negedge clock);
        check_reset_outputs("mid_line_reset");
        reset = 1'b0;
        m_idle = 1'b1; m_row = 0; m_es = 1'b0; m_el = 1'b0; m_ef = 1'b0;
        tick(8);

        // Subsequent frame starts at address 0
        do_vsync();
        for (int l = 0; l < 3; l++) begin
            send_line(W, 1, 1'b0);
            check_status("after_reset");
        end

        tick(10);
        check("final_pending_writes", exp_q.size(), 0);
        check("final_frame_done_count", done_seen, m_done);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
